// File: rtl/block_xfer_seq_pkg.sv
// Shared definitions for the block (multiple-register) transfer sequencer:
// FSM encoding, addressing-mode codes, opcode and word stride.
package block_xfer_seq_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StReq,
      StWb,
      StDone
   } state_e;

   // Encoded as {P, U} from IR[24:23].
   typedef enum logic [1:0] {
      ModeDa = 2'b00,
      ModeIa = 2'b01,
      ModeDb = 2'b10,
      ModeIb = 2'b11
   } mode_e;

   localparam logic [2:0]  OpBlockXfer = 3'b100;
   localparam int unsigned WordStride  = 4;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] cnt;
      cnt = '0;
      for (int i = 0; i < 16; i++) begin
         cnt = cnt + {4'b0000, v[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/lsb_prienc.sv
// Lowest-set-bit priority encoder: index of the lowest set bit of a 16-bit vector.
module lsb_prienc (
   input  logic [15:0] req_i,
   output logic [3:0]  idx_o,
   output logic        valid_o
);

   // Scan downwards so the lowest set bit is the last one written.
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = 15; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o   = 4'(i);
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/block_xfer_seq.sv
// Block transfer sequencer: walks the register list of an LDM/STM instruction,
// issuing one word access per listed register and an optional base writeback.
module block_xfer_seq
   import block_xfer_seq_pkg::*;
#(
   parameter int unsigned AW = 32
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          START,
   input  logic [31:0]   IR,
   input  logic [AW-1:0] BASE,
   input  logic          MOC,
   output logic          BUSY,
   output logic          MEM_EN,
   output logic          RW,
   output logic [AW-1:0] MAR,
   output logic [3:0]    REG_NUM,
   output logic          LOAD_WE,
   output logic          WB_EN,
   output logic [AW-1:0] WB_VAL,
   output logic          DONE
);

   state_e        state_q, state_d;
   logic [15:0]   list_q, list_d;
   logic [4:0]    n_q, n_d;
   logic          p_q, p_d, u_q, u_d, w_q, w_d;
   logic [AW-1:0] base_q, base_d;
   logic [AW-1:0] mar_q, mar_d;
   logic [3:0]    reg_num_q, reg_num_d;
   logic          rw_q, rw_d;
   logic          mem_en_q, mem_en_d;
   logic          busy_q, busy_d;
   logic          wb_en_q, wb_en_d;
   logic [AW-1:0] wb_val_q, wb_val_d;
   logic          done_q, done_d;

   logic [15:0]   pe_in;
   logic [3:0]    pe_idx;
   logic          pe_valid;
   logic [AW-1:0] four_n;
   logic [AW-1:0] stride;
   logic [AW-1:0] start_addr;
   logic          unused_ir;

   assign unused_ir = ^{IR[31:28], IR[22], IR[19:16]};
   assign four_n    = AW'({n_q, 2'b00});
   assign stride    = AW'(WordStride);

   // In REQ the encoder looks ahead past the register currently on the bus.
   assign pe_in = (state_q == StReq) ? (list_q & ~(16'b1 << reg_num_q)) : list_q;

   lsb_prienc u_lsb_prienc (
      .req_i   (pe_in),
      .idx_o   (pe_idx),
      .valid_o (pe_valid)
   );

   always_comb begin
      case (mode_e'({p_q, u_q}))
         ModeIa:  start_addr = base_q;
         ModeIb:  start_addr = base_q + stride;
         ModeDa:  start_addr = base_q - four_n + stride;
         default: start_addr = base_q - four_n;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      list_d    = list_q;
      n_d       = n_q;
      p_d       = p_q;
      u_d       = u_q;
      w_d       = w_q;
      base_d    = base_q;
      mar_d     = mar_q;
      reg_num_d = reg_num_q;
      rw_d      = rw_q;
      mem_en_d  = mem_en_q;
      busy_d    = busy_q;
      wb_en_d   = 1'b0;
      wb_val_d  = wb_val_q;
      done_d    = 1'b0;
      case (state_q)
         StIdle: begin
            if (START && (IR[27:25] == OpBlockXfer)) begin
               state_d = StSetup;
               list_d  = IR[15:0];
               n_d     = popcount16(IR[15:0]);
               p_d     = IR[24];
               u_d     = IR[23];
               w_d     = IR[21];
               rw_d    = IR[20];
               base_d  = BASE;
               busy_d  = 1'b1;
            end
         end
         StSetup: begin
            mar_d     = start_addr;
            reg_num_d = pe_idx;
            if (pe_valid) begin
               state_d  = StReq;
               mem_en_d = 1'b1;
            end else begin
               state_d = StDone;
               done_d  = 1'b1;
            end
         end
         StReq: begin
            if (MOC) begin
               mar_d  = mar_q + stride;
               list_d = pe_in;
               if (pe_valid) begin
                  reg_num_d = pe_idx;
               end else begin
                  mem_en_d = 1'b0;
                  if (w_q) begin
                     state_d  = StWb;
                     wb_en_d  = 1'b1;
                     wb_val_d = u_q ? (base_q + four_n) : (base_q - four_n);
                  end else begin
                     state_d = StDone;
                     done_d  = 1'b1;
                  end
               end
            end
         end
         StWb: begin
            state_d = StDone;
            done_d  = 1'b1;
         end
         StDone: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q   <= StIdle;
         list_q    <= '0;
         n_q       <= '0;
         p_q       <= 1'b0;
         u_q       <= 1'b0;
         w_q       <= 1'b0;
         base_q    <= '0;
         mar_q     <= '0;
         reg_num_q <= '0;
         rw_q      <= 1'b0;
         mem_en_q  <= 1'b0;
         busy_q    <= 1'b0;
         wb_en_q   <= 1'b0;
         wb_val_q  <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         list_q    <= list_d;
         n_q       <= n_d;
         p_q       <= p_d;
         u_q       <= u_d;
         w_q       <= w_d;
         base_q    <= base_d;
         mar_q     <= mar_d;
         reg_num_q <= reg_num_d;
         rw_q      <= rw_d;
         mem_en_q  <= mem_en_d;
         busy_q    <= busy_d;
         wb_en_q   <= wb_en_d;
         wb_val_q  <= wb_val_d;
         done_q    <= done_d;
      end
   end

   assign BUSY    = busy_q;
   assign MEM_EN  = mem_en_q;
   assign RW      = rw_q;
   assign MAR     = mar_q;
   assign REG_NUM = reg_num_q;
   assign LOAD_WE = mem_en_q & MOC & rw_q;
   assign WB_EN   = wb_en_q;
   assign WB_VAL  = wb_val_q;
   assign DONE    = done_q;

endmodule

// File: tb/tb_block_xfer_seq.sv
// Directed bench for block_xfer_seq: addressing modes, MOC wait, empty list,
// ignored starts and mid-transfer reset, with hand-computed expectations.
module tb_block_xfer_seq;

   logic        CLK, RST_N, START, MOC;
   logic [31:0] IR, BASE;
   logic        BUSY, MEM_EN, RW, LOAD_WE, WB_EN, DONE;
   logic [31:0] MAR, WB_VAL;
   logic [3:0]  REG_NUM;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] ir;
      logic [31:0] base;
      logic [2:0]  n;
      logic [15:0] regs;   // expected register order, one nibble per transfer
      logic [31:0] addr0;
      logic        rw;
      logic        w;
      logic [31:0] wbval;
   } vec_t;

   block_xfer_seq #(.AW(32)) dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .START   (START),
      .IR      (IR),
      .BASE    (BASE),
      .MOC     (MOC),
      .BUSY    (BUSY),
      .MEM_EN  (MEM_EN),
      .RW      (RW),
      .MAR     (MAR),
      .REG_NUM (REG_NUM),
      .LOAD_WE (LOAD_WE),
      .WB_EN   (WB_EN),
      .WB_VAL  (WB_VAL),
      .DONE    (DONE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Present START for one edge; returns just after the accept edge.
   task automatic do_start(input logic [31:0] ir, input logic [31:0] base);
      @(negedge CLK);
      START = 1'b1;
      IR    = ir;
      BASE  = base;
      @(posedge CLK);
      #1 START = 1'b0;
   endtask

   task automatic test_reset();
      RST_N = 1'b0; START = 1'b0; MOC = 1'b0; IR = '0; BASE = '0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      checks++;
      if ({BUSY, MEM_EN, RW, LOAD_WE, WB_EN, DONE} !== 6'b0 || MAR !== 32'h0
          || REG_NUM !== 4'h0 || WB_VAL !== 32'h0) begin
         errors++;
         $display("FAIL reset: got busy%b mem%b rw%b lwe%b wb%b done%b mar%h reg%h wbv%h expected all 0",
                  BUSY, MEM_EN, RW, LOAD_WE, WB_EN, DONE, MAR, REG_NUM, WB_VAL);
      end
      RST_N = 1'b1;
   endtask

   task automatic test_modes();
      vec_t vecs [3];
      int   loads;
      vecs[0] = '{ir: 32'hE8B0000F, base: 32'h100, n: 3'd4, regs: 16'h3210, addr0: 32'h100,
                  rw: 1'b1, w: 1'b1, wbval: 32'h110};
      vecs[1] = '{ir: 32'hE92D4010, base: 32'h1000, n: 3'd2, regs: 16'h00E4, addr0: 32'hFF8,
                  rw: 1'b0, w: 1'b1, wbval: 32'hFF8};
      vecs[2] = '{ir: 32'hE8100006, base: 32'h200, n: 3'd2, regs: 16'h0021, addr0: 32'h1FC,
                  rw: 1'b1, w: 1'b0, wbval: 32'h0};
      MOC = 1'b1;
      for (int v = 0; v < 3; v++) begin
         int n, w;
         n = int'(vecs[v].n);
         w = int'(vecs[v].w);
         loads = 0;
         do_start(vecs[v].ir, vecs[v].base);
         for (int c = 1; c <= n + 3 + w; c++) begin
            logic in_req, exp_wb, exp_done, exp_busy;
            int idx;
            @(negedge CLK);
            in_req   = (c >= 2) && (c <= n + 1);
            idx      = c - 2;
            exp_wb   = (w == 1) && (c == n + 2);
            exp_done = (c == n + 2 + w);
            exp_busy = (c <= n + 2 + w);
            if (LOAD_WE === 1'b1) loads++;
            checks++;
            if (MEM_EN !== in_req || WB_EN !== exp_wb || DONE !== exp_done || BUSY !== exp_busy) begin
               errors++;
               $display("FAIL modes[%0d] c%0d ctl: got mem%b wb%b done%b busy%b expected mem%b wb%b done%b busy%b",
                        v, c, MEM_EN, WB_EN, DONE, BUSY, in_req, exp_wb, exp_done, exp_busy);
            end
            if (in_req) begin
               checks++;
               if (MAR !== vecs[v].addr0 + 32'(4 * idx) || REG_NUM !== vecs[v].regs[idx*4 +: 4]
                   || RW !== vecs[v].rw) begin
                  errors++;
                  $display("FAIL modes[%0d] c%0d xfer: got mar%h reg%0d rw%b expected mar%h reg%0d rw%b",
                           v, c, MAR, REG_NUM, RW, vecs[v].addr0 + 32'(4 * idx),
                           vecs[v].regs[idx*4 +: 4], vecs[v].rw);
               end
            end
            if (exp_wb) begin
               checks++;
               if (WB_VAL !== vecs[v].wbval) begin
                  errors++;
                  $display("FAIL modes[%0d] wb_val: got %h expected %h", v, WB_VAL, vecs[v].wbval);
               end
            end
         end
         checks++;
         if (loads !== (vecs[v].rw ? n : 0)) begin
            errors++;
            $display("FAIL modes[%0d] load_we count: got %0d expected %0d", v, loads,
                     vecs[v].rw ? n : 0);
         end
      end
   endtask

   task automatic test_moc_wait();
      int loads = 0;
      MOC = 1'b0;
      do_start(32'hE8B00003, 32'h40);
      @(negedge CLK);
      checks++;
      if (MEM_EN !== 1'b0 || BUSY !== 1'b1) begin
         errors++;
         $display("FAIL moc_wait setup: got mem%b busy%b expected mem0 busy1", MEM_EN, BUSY);
      end
      for (int t = 0; t < 2; t++) begin
         for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            checks++;
            if (MEM_EN !== 1'b1 || MAR !== 32'h40 + 32'(4 * t) || REG_NUM !== 4'(t)) begin
               errors++;
               $display("FAIL moc_wait t%0d k%0d hold: got mem%b mar%h reg%0d expected mem1 mar%h reg%0d",
                        t, k, MEM_EN, MAR, REG_NUM, 32'h40 + 32'(4 * t), t);
            end
            MOC = (k == 3);
            #1;
            if (LOAD_WE === 1'b1) loads++;
         end
      end
      @(negedge CLK);
      MOC = 1'b0;
      checks++;
      if (WB_EN !== 1'b1 || WB_VAL !== 32'h48 || MEM_EN !== 1'b0) begin
         errors++;
         $display("FAIL moc_wait wb: got wb%b val%h mem%b expected wb1 val00000048 mem0",
                  WB_EN, WB_VAL, MEM_EN);
      end
      @(negedge CLK);
      checks++;
      if (DONE !== 1'b1) begin
         errors++;
         $display("FAIL moc_wait done: got %b expected 1", DONE);
      end
      checks++;
      if (loads !== 2) begin
         errors++;
         $display("FAIL moc_wait load_we count: got %0d expected 2", loads);
      end
      @(negedge CLK);
   endtask

   task automatic test_empty();
      MOC = 1'b1;
      do_start(32'hE8B00000, 32'h300);
      @(negedge CLK);
      checks++;
      if (BUSY !== 1'b1 || MEM_EN !== 1'b0 || DONE !== 1'b0) begin
         errors++;
         $display("FAIL empty c1: got busy%b mem%b done%b expected busy1 mem0 done0",
                  BUSY, MEM_EN, DONE);
      end
      @(negedge CLK);
      checks++;
      if (DONE !== 1'b1 || MEM_EN !== 1'b0 || WB_EN !== 1'b0) begin
         errors++;
         $display("FAIL empty c2: got done%b mem%b wb%b expected done1 mem0 wb0", DONE, MEM_EN, WB_EN);
      end
      @(negedge CLK);
      checks++;
      if (BUSY !== 1'b0 || DONE !== 1'b0) begin
         errors++;
         $display("FAIL empty c3: got busy%b done%b expected busy0 done0", BUSY, DONE);
      end
   endtask

   task automatic test_ignored_start();
      do_start(32'hE5900000, 32'h500);
      @(negedge CLK);
      checks++;
      if (BUSY !== 1'b0) begin
         errors++;
         $display("FAIL bad_opcode busy: got %b expected 0", BUSY);
      end
      MOC = 1'b1;
      do_start(32'hE8B00003, 32'h40);
      @(negedge CLK);
      START = 1'b1; IR = 32'hE8B0000C; BASE = 32'h900;
      @(negedge CLK);
      START = 1'b0;
      checks++;
      if (MAR !== 32'h40 || REG_NUM !== 4'd0) begin
         errors++;
         $display("FAIL busy_start: got mar%h reg%0d expected mar00000040 reg0", MAR, REG_NUM);
      end
      repeat (5) @(negedge CLK);
      checks++;
      if (BUSY !== 1'b0 || MEM_EN !== 1'b0) begin
         errors++;
         $display("FAIL busy_start idle: got busy%b mem%b expected busy0 mem0", BUSY, MEM_EN);
      end
   endtask

   task automatic test_reset_mid();
      logic seen_done = 1'b0;
      MOC = 1'b1;
      do_start(32'hE8B0000F, 32'h100);
      repeat (3) @(negedge CLK);
      checks++;
      if (MAR !== 32'h104 || REG_NUM !== 4'd1) begin
         errors++;
         $display("FAIL reset_mid pre: got mar%h reg%0d expected mar00000104 reg1", MAR, REG_NUM);
      end
      RST_N = 1'b0;
      @(negedge CLK);
      checks++;
      if ({BUSY, MEM_EN, RW, LOAD_WE, WB_EN, DONE} !== 6'b0 || MAR !== 32'h0
          || REG_NUM !== 4'h0 || WB_VAL !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid: got busy%b mem%b rw%b lwe%b wb%b done%b mar%h reg%h wbv%h expected all 0",
                  BUSY, MEM_EN, RW, LOAD_WE, WB_EN, DONE, MAR, REG_NUM, WB_VAL);
      end
      START = 1'b1; IR = 32'hE8B0000F; BASE = 32'h100;
      @(negedge CLK);
      START = 1'b0;
      checks++;
      if (BUSY !== 1'b0) begin
         errors++;
         $display("FAIL reset_priority busy: got %b expected 0", BUSY);
      end
      RST_N = 1'b1;
      do_start(32'hE8B0000F, 32'h100);
      repeat (2) @(negedge CLK);
      checks++;
      if (MEM_EN !== 1'b1 || MAR !== 32'h100 || REG_NUM !== 4'd0) begin
         errors++;
         $display("FAIL reset_restart: got mem%b mar%h reg%0d expected mem1 mar00000100 reg0",
                  MEM_EN, MAR, REG_NUM);
      end
      for (int i = 0; i < 20 && !seen_done; i++) begin
         @(negedge CLK);
         if (DONE === 1'b1) seen_done = 1'b1;
      end
      checks++;
      if (!seen_done) begin
         errors++;
         $display("FAIL reset_restart done: got no DONE within 20 cycles expected DONE");
      end
   endtask

   initial begin
      test_reset();
      test_modes();
      test_moc_wait();
      test_empty();
      test_ignored_start();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
